cpu_reg_wb_ctrl: RTL

- Master-side controller for the CPU register bank interface: drives the bank's read selects, its single-cycle ALU write port and its multiplier write-back port.
- Tracks destination registers of in-flight multi-cycle multiplies in a scoreboard and stalls decode on RAW/WAW hazards.
- Bypasses same-cycle write-back data onto decode operands, because bank writes land only at the next clock edge.
- Sits between decode, the ALU/mul write-back paths and the register bank.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/cpu_reg_scoreboard.sv | 59 +++++
 rtl/cpu_reg_wb_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and sizing for the register-bank write-back controller.
// All cpu_reg_* modules import this package.
package cpu_pkg;
  localparam int NUM_REGS         = 32;
  localparam int REG_WIDTH        = 32;
  localparam int MAX_MUL_INFLIGHT = 4;

  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int INFL_W    = $clog2(MAX_MUL_INFLIGHT) + 1;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;
  typedef logic [INFL_W-1:0]    infl_t;
endpackage

// File: rtl/cpu_reg_scoreboard.sv
// Pending-destination scoreboard for in-flight multiplies,
// with in-flight counter and sticky write-back error flag.
module cpu_reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_i,
  input  reg_idx_t            issue_rd_i,
  input  logic                mul_wb_valid_i,
  input  reg_idx_t            mul_wb_reg_i,
  input  logic                alu_wb_valid_i,
  input  reg_idx_t            alu_wb_reg_i,
  output logic [NUM_REGS-1:0] pending_o,
  output infl_t               inflight_o,
  output logic                wb_error_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  infl_t               cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                spurious;
  logic                collide;

  assign spurious = mul_wb_valid_i & ~pend_q[mul_wb_reg_i];
  assign collide  = alu_wb_valid_i & mul_wb_valid_i
                  & (alu_wb_reg_i == mul_wb_reg_i);

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = err_q | spurious | collide;
    // clear first so a same-register issue wins
    if (mul_wb_valid_i) pend_d[mul_wb_reg_i] = 1'b0;
    if (issue_i)        pend_d[issue_rd_i]   = 1'b1;
    if (issue_i && !mul_wb_valid_i) begin
      cnt_d = cnt_q + infl_t'(1);
    end else if (!issue_i && mul_wb_valid_i && cnt_q != '0) begin
      cnt_d = cnt_q - infl_t'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign pending_o  = pend_q;
  assign inflight_o = cnt_q;
  assign wb_error_o = err_q;

endmodule

// File: rtl/cpu_reg_wb_ctrl.sv
// Register-bank master: read selects, write-port pass-through,
// operand bypass and multiply hazard stall for decode.
module cpu_reg_wb_ctrl
  import cpu_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      dec_valid,
  input  reg_idx_t  dec_rs_a,
  input  reg_idx_t  dec_rs_b,
  input  reg_idx_t  dec_rd,
  input  logic      dec_writes_rd,
  input  logic      dec_is_mul,
  output logic      dec_stall,
  output reg_data_t operand_a,
  output reg_data_t operand_b,
  input  logic      alu_wb_valid,
  input  reg_idx_t  alu_wb_reg,
  input  reg_data_t alu_wb_data,
  input  logic      mul_wb_valid,
  input  reg_idx_t  mul_wb_reg,
  input  reg_data_t mul_wb_data,
  output reg_idx_t  read_reg_a,
  output reg_idx_t  read_reg_b,
  input  reg_data_t read_data_a,
  input  reg_data_t read_data_b,
  output logic      write_enable,
  output reg_idx_t  write_reg,
  output reg_data_t write_data,
  output logic      write_enable_mul,
  output reg_idx_t  write_reg_mul,
  output reg_data_t write_data_mul,
  output infl_t     mul_inflight,
  output logic      wb_error
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] wb_mask;
  logic [NUM_REGS-1:0] pend_eff;
  logic                raw, waw, full, issue;

  assign read_reg_a = dec_rs_a;
  assign read_reg_b = dec_rs_b;

  // mul before alu: the bank applies the mul write last
  assign operand_a =
    (mul_wb_valid && mul_wb_reg == dec_rs_a) ? mul_wb_data :
    (alu_wb_valid && alu_wb_reg == dec_rs_a) ? alu_wb_data :
    read_data_a;
  assign operand_b =
    (mul_wb_valid && mul_wb_reg == dec_rs_b) ? mul_wb_data :
    (alu_wb_valid && alu_wb_reg == dec_rs_b) ? alu_wb_data :
    read_data_b;

  assign write_enable     = alu_wb_valid & reset;
  assign write_reg        = alu_wb_reg;
  assign write_data       = alu_wb_data;
  assign write_enable_mul = mul_wb_valid & reset;
  assign write_reg_mul    = mul_wb_reg;
  assign write_data_mul   = mul_wb_data;

  assign wb_mask  = mul_wb_valid
                  ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << mul_wb_reg)
                  : '0;
  assign pend_eff = pending & ~wb_mask;

  assign raw  = pend_eff[dec_rs_a] | pend_eff[dec_rs_b];
  assign waw  = dec_writes_rd & pend_eff[dec_rd];
  assign full = dec_is_mul & dec_writes_rd & ~mul_wb_valid
              & (mul_inflight == infl_t'(MAX_MUL_INFLIGHT));

  assign dec_stall = dec_valid & (raw | waw | full);
  assign issue     = dec_valid & ~dec_stall
                   & dec_is_mul & dec_writes_rd;

  cpu_reg_scoreboard u_sb (
    .clock          (clock),
    .reset          (reset),
    .issue_i        (issue),
    .issue_rd_i     (dec_rd),
    .mul_wb_valid_i (mul_wb_valid),
    .mul_wb_reg_i   (mul_wb_reg),
    .alu_wb_valid_i (alu_wb_valid),
    .alu_wb_reg_i   (alu_wb_reg),
    .pending_o      (pending),
    .inflight_o     (mul_inflight),
    .wb_error_o     (wb_error)
  );

endmodule
